// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard control for a 5-stage pipeline. Drives the enable/flush controls
//   of the F/D, D/X and X/M pipeline registers and the PC enable. Detects
//   load-use, taken branch/jump and multi-cycle mult/div hazards. It also
//   sequences the multdiv start/ready handshake and keeps a saturating
//   stall-cycle counter.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   fd_instruction instruction in the F/D register (decode stage)
//   dx_instruction instruction in the D/X register (execute stage)
//   branch_taken   execute resolved a taken branch/jump this cycle
//   md_ready       multdiv result valid pulse
//   pc_enable, fd_enable, dx_enable, xm_enable   register load enables
//   fd_flush, dx_flush                           zero the register input
//   ctrl_mult, ctrl_div                          one-cycle start pulses
//   md_error       one-cycle pulse when a multdiv operation times out
//   stall_count    saturating count of cycles with pc_enable=0
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fd_instruction,
    input  logic [31:0]      dx_instruction,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_enable,
    output logic             fd_enable,
    output logic             dx_enable,
    output logic             xm_enable,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MDC_W = $clog2(MD_TIMEOUT + 1);
    // The forced release fires in the cycle where the busy counter would
    // step to MD_TIMEOUT-1, i.e. MD_TIMEOUT-1 cycles after the start pulse.
    localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 2);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t            state_q, state_d;
    logic [MDC_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  stall_count_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Field decode
    logic [4:0] fd_op, fd_rs, fd_rt, fd_rd;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       fd_is_r, fd_rs_src, fd_rd_src;
    logic       dx_is_lw, dx_is_mul, dx_is_div, load_use;
    logic       unused_bits;

    assign fd_op    = fd_instruction[31:27];
    assign fd_rd    = fd_instruction[26:22];
    assign fd_rs    = fd_instruction[21:17];
    assign fd_rt    = fd_instruction[16:12];
    assign dx_op    = dx_instruction[31:27];
    assign dx_rd    = dx_instruction[26:22];
    assign dx_aluop = dx_instruction[6:2];

    assign unused_bits = ^{fd_instruction[11:0], dx_instruction[21:7],
                           dx_instruction[1:0]};

    assign fd_is_r   = (fd_op == OP_R);
    assign fd_rs_src = fd_is_r || (fd_op == OP_ADDI) || (fd_op == OP_SW) ||
                       (fd_op == OP_LW) || (fd_op == OP_BNE) || (fd_op == OP_BLT);
    assign fd_rd_src = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                       (fd_op == OP_BLT) || (fd_op == OP_JR);

    assign dx_is_lw  = (dx_op == OP_LW);
    assign dx_is_mul = (dx_op == OP_R) && (dx_aluop == ALU_MUL);
    assign dx_is_div = (dx_op == OP_R) && (dx_aluop == ALU_DIV);

    // r0 is hardwired zero, so a load targeting it can never create a hazard.
    assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                      ((fd_rs_src && (fd_rs == dx_rd)) ||
                       (fd_is_r   && (fd_rt == dx_rd)) ||
                       (fd_rd_src && (fd_rd == dx_rd)));

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        pc_enable = 1'b1;
        fd_enable = 1'b1;
        dx_enable = 1'b1;
        xm_enable = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        md_error  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (dx_is_mul || dx_is_div) begin
                    ctrl_mult = dx_is_mul;
                    ctrl_div  = dx_is_div;
                    pc_enable = 1'b0;
                    fd_enable = 1'b0;
                    dx_enable = 1'b0;
                    xm_enable = 1'b0;
                    md_cnt_d  = '0;
                    state_d   = MD_BUSY;
                end else if (load_use) begin
                    // One bubble: the flushed D/X clears the hazard next cycle.
                    pc_enable = 1'b0;
                    fd_enable = 1'b0;
                    dx_flush  = 1'b1;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q + MDC_W'(1);
                if (md_ready) begin
                    state_d = RUN;
                end else if (md_cnt_q == MD_LAST) begin
                    md_error = 1'b1;
                    state_d  = RUN;
                end else begin
                    pc_enable = 1'b0;
                    fd_enable = 1'b0;
                    dx_enable = 1'b0;
                    xm_enable = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        // While reset is held the pipeline sees plain default controls.
        if (!rst) begin
            pc_enable = 1'b1;
            fd_enable = 1'b1;
            dx_enable = 1'b1;
            xm_enable = 1'b1;
            fd_flush  = 1'b0;
            dx_flush  = 1'b0;
            ctrl_mult = 1'b0;
            ctrl_div  = 1'b0;
            md_error  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            md_cnt_q      <= '0;
            stall_count_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (!pc_enable) begin
                stall_count_q <= sat_inc(stall_count_q);
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fd_instruction = '0;
    logic [31:0] dx_instruction = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;

    logic        pc_enable, fd_enable, dx_enable, xm_enable;
    logic        fd_flush, dx_flush, ctrl_mult, ctrl_div, md_error;
    logic [15:0] stall_count;

    logic        s_pc, s_fd, s_dx, s_xm, s_fdf, s_dxf, s_mul, s_div, s_err;
    logic [3:0]  s_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .fd_instruction(fd_instruction), .dx_instruction(dx_instruction),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .pc_enable(pc_enable), .fd_enable(fd_enable), .dx_enable(dx_enable),
        .xm_enable(xm_enable), .fd_flush(fd_flush), .dx_flush(dx_flush),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_error(md_error),
        .stall_count(stall_count)
    );

    // Narrow-counter copy driven by the same stimulus for the saturation check.
    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .fd_instruction(fd_instruction), .dx_instruction(dx_instruction),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .pc_enable(s_pc), .fd_enable(s_fd), .dx_enable(s_dx),
        .xm_enable(s_xm), .fd_flush(s_fdf), .dx_flush(s_dxf),
        .ctrl_mult(s_mul), .ctrl_div(s_div), .md_error(s_err),
        .stall_count(s_count)
    );

    // {pc, fd, dx, xm, fd_flush, dx_flush, ctrl_mult, ctrl_div, md_error}
    localparam logic [8:0] C_DEF  = 9'b1111_00_000;
    localparam logic [8:0] C_LU   = 9'b0011_01_000;
    localparam logic [8:0] C_BR   = 9'b1111_11_000;
    localparam logic [8:0] C_MUL  = 9'b0000_00_100;
    localparam logic [8:0] C_DIV  = 9'b0000_00_010;
    localparam logic [8:0] C_BUSY = 9'b0000_00_000;
    localparam logic [8:0] C_ERR  = 9'b1111_00_001;

    typedef struct {
        string      nm;
        logic [8:0] ctl;
        int         cnt;
        int         cnt4;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt,
                                          input logic [4:0] aluop);
        return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input int rd,
                                          input int rs);
        return {op, 5'(rd), 5'(rs), 17'd0};
    endfunction

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    logic [31:0] NOP, LW5, LW0, ADD, ADD0, SUB, ADDI5, SW5, MUL, DIV;

    // One cycle of stimulus: drive inputs just after the edge and queue the
    // hand-computed response expected for this cycle.
    task automatic step(input string nm, input logic r, input logic [31:0] fd,
                        input logic [31:0] dx, input logic br, input logic rdy,
                        input logic [8:0] ctl, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        fd_instruction = fd;
        dx_instruction = dx;
        branch_taken   = br;
        md_ready       = rdy;
        e.nm   = nm;
        e.ctl  = ctl;
        e.cnt  = cnt;
        e.cnt4 = sat4(cnt);
        q.push_back(e);
    endtask

    // Monitor: control outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {pc_enable, fd_enable, dx_enable, xm_enable, fd_flush,
                   dx_flush, ctrl_mult, ctrl_div, md_error};
            total++;
            if (act !== e.ctl || stall_count !== 16'(e.cnt) ||
                s_count !== 4'(e.cnt4) ||
                {s_pc, s_fd, s_dx, s_xm, s_fdf, s_dxf, s_mul, s_div, s_err} !== e.ctl) begin
                bad++;
                $display("FAIL %s: got ctl=%b cnt=%0d cnt4=%0d, expected ctl=%b cnt=%0d cnt4=%0d",
                         e.nm, act, stall_count, s_count, e.ctl, e.cnt, e.cnt4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        NOP   = '0;
        LW5   = itype(5'b01000, 5, 2);
        LW0   = itype(5'b01000, 0, 2);
        ADD   = rtype(7, 5, 3, 5'b00000);
        ADD0  = rtype(7, 0, 3, 5'b00000);
        SUB   = rtype(7, 3, 5, 5'b00001);
        ADDI5 = itype(5'b00101, 5, 3);
        SW5   = itype(5'b00111, 5, 3);
        MUL   = rtype(4, 1, 2, 5'b00110);
        DIV   = rtype(6, 4, 3, 5'b00111);

        // Reset held with a load-use pair present: defaults only.
        step("reset_hold",     0, ADD,   LW5, 0, 0, C_DEF, 0);
        // Load-use
        step("lu_stall",       1, ADD,   LW5, 0, 0, C_LU,  0);
        step("lu_bubble",      1, ADD,   NOP, 0, 0, C_DEF, 1);
        step("lu_advance",     1, NOP,   ADD, 0, 0, C_DEF, 1);
        step("lu_rd0",         1, ADD0,  LW0, 0, 0, C_DEF, 1);
        step("lu_rt_src",      1, SUB,   LW5, 0, 0, C_LU,  1);
        step("lu_rt_bubble",   1, SUB,   NOP, 0, 0, C_DEF, 2);
        step("lu_addi_rd",     1, ADDI5, LW5, 0, 0, C_DEF, 2);
        step("lu_sw_rd",       1, SW5,   LW5, 0, 0, C_LU,  2);
        step("lu_sw_bubble",   1, SW5,   NOP, 0, 0, C_DEF, 3);
        // Branch beats load-use and mult/div
        step("br_over_lu",     1, ADD,   LW5, 1, 0, C_BR,  3);
        step("br_after",       1, NOP,   NOP, 0, 0, C_DEF, 3);
        step("br_over_mul",    1, NOP,   MUL, 1, 0, C_BR,  3);
        step("br_mul_after",   1, NOP,   NOP, 0, 0, C_DEF, 3);
        // Multiply, 17 stall cycles, with div waiting in decode
        step("mul_start",      1, DIV,   MUL, 0, 0, C_MUL, 3);
        for (int i = 1; i <= 16; i++)
            step("mul_busy",   1, DIV,   MUL, (i == 3), 0, C_BUSY, 3 + i);
        step("mul_ready",      1, DIV,   MUL, 0, 1, C_DEF, 20);
        // Back-to-back divide, never answered: timeout
        step("div_start",      1, NOP,   DIV, 0, 0, C_DIV, 20);
        for (int j = 1; j <= 38; j++)
            step("div_busy",   1, NOP,   DIV, 0, 0, C_BUSY, 20 + j);
        step("div_timeout",    1, NOP,   DIV, 0, 0, C_ERR, 59);
        step("ready_in_run",   1, NOP,   NOP, 0, 1, C_DEF, 59);
        // Reset in the middle of MD_BUSY
        step("mul2_start",     1, NOP,   MUL, 0, 0, C_MUL, 59);
        for (int k = 1; k <= 4; k++)
            step("mul2_busy",  1, NOP,   MUL, 0, 0, C_BUSY, 59 + k);
        step("reset_mid_busy", 0, NOP,   MUL, 0, 0, C_DEF, 0);
        step("reset_held",     0, NOP,   MUL, 0, 1, C_DEF, 0);
        step("mul3_start",     1, NOP,   MUL, 0, 0, C_MUL, 0);
        step("mul3_ready",     1, NOP,   MUL, 0, 1, C_DEF, 1);
        step("mul3_after",     1, NOP,   NOP, 0, 0, C_DEF, 1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
